// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: load/start/pause strobes, 1 Hz tick enable, registered outputs.
// Latency: every input takes effect one cycle later. No backpressure; strobes are never stalled.
module countdown_timer #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [6:0] MAX_V = 7'(MAX_MIN);

  state_t      state;
  logic [6:0]  min_val;
  logic        load_ok;
  logic        count_zero;
  logic [15:0] count_dec;

  // Digit-wise borrow chain so the count never passes through a binary value.
  function automatic logic [15:0] dec_bcd(input logic [15:0] c);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = c;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign min_val    = 7'(min_in[7:4]) * 7'd10 + 7'(min_in[3:0]);
  assign load_ok    = (min_in[7:4] <= 4'd9) && (min_in[3:0] <= 4'd9) &&
                      (sec_in[7:4] <= 4'd5) && (sec_in[3:0] <= 4'd9) &&
                      (min_val <= MAX_V);
  assign count_zero = (min_out == 8'h00) && (sec_out == 8'h00);
  assign count_dec  = dec_bcd({min_out, sec_out});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      min_out  <= 8'h00;
      sec_out  <= 8'h00;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          min_out <= min_in;
          sec_out <= sec_in;
          state   <= IDLE;
          running <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && !count_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick && !count_zero) begin
              {min_out, sec_out} <= count_dec;
              if (count_dec == 16'h0000) begin
                state   <= EXPIRED;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (!pause && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            // EXPIRED holds 00:00 until a valid load or reset.
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
